// File: rtl/ex_branch_unit.sv
// Execute-stage ALU and branch resolver with a one-deep registered output under valid/ready.
// Also keeps a saturating count of taken branches delivered downstream.
module ex_branch_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [1:0]       Branchcontrol,
  input  logic             branch,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic             branch_taken,
  output logic [XLEN-1:0]  branch_target,
  output logic             illegal_op,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            r_state, w_next;
  logic [XLEN-1:0]   r_result, r_target;
  logic              r_zero, r_taken, r_illegal;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept, w_hs;
  logic [XLEN-1:0]   w_res, w_target;
  logic              w_illegal, w_cond, w_taken;

  assign out_valid     = (r_state == FULL);
  assign in_ready      = !flush && (!out_valid || out_ready);
  assign w_accept      = in_valid && in_ready;
  assign w_hs          = out_valid && out_ready;

  assign result        = r_result;
  assign zero          = r_zero;
  assign branch_taken  = r_taken;
  assign branch_target = r_target;
  assign illegal_op    = r_illegal;
  assign taken_count   = r_cnt;

  always_comb begin
    w_next = r_state;
    if (flush)         w_next = EMPTY;
    else if (w_accept) w_next = FULL;
    else if (w_hs)     w_next = EMPTY;
  end

  always_comb begin
    w_res     = '0;
    w_illegal = 1'b0;
    case (operation)
      4'b0000: w_res = a & b;
      4'b0001: w_res = a | b;
      4'b0010: w_res = a + b;
      4'b0110: w_res = a - b;
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (Branchcontrol)
      2'b00: w_cond = (a == b);
      2'b01: w_cond = (a != b);
      2'b10: w_cond = ($signed(a) <  $signed(b));
      2'b11: w_cond = ($signed(a) >= $signed(b));
      default: w_cond = 1'b0;
    endcase
  end

  // Condition is evaluated on the operands directly, but an illegal op vetoes it.
  assign w_taken  = branch && w_cond && !w_illegal;
  assign w_target = pc + (imm << 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= EMPTY;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result  <= '0;
      r_target  <= '0;
      r_zero    <= 1'b0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_result  <= w_res;
      r_target  <= w_target;
      r_zero    <= (w_res == '0);
      r_taken   <= w_taken;
      r_illegal <= w_illegal;
    end
  end

  // Counts taken branches at the moment they leave; a flush squashes the delivery.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cnt <= '0;
    else if (w_hs && r_taken && !flush && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: tb/tb_ex_branch_unit.sv
// Bench for ex_branch_unit: directed scenarios then random traffic, all against a
// cycle-level behavioural model of the output slot and taken counter.
module tb_ex_branch_unit;
  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [3:0]       operation;
  logic [1:0]       Branchcontrol;
  logic             branch;
  logic [XLEN-1:0]  a, b, pc, imm;
  logic             flush;
  logic             out_valid, out_ready;
  logic [XLEN-1:0]  result, branch_target;
  logic             zero, branch_taken, illegal_op;
  logic [CNT_W-1:0] taken_count;

  ex_branch_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .Branchcontrol(Branchcontrol), .branch(branch),
    .a(a), .b(b), .pc(pc), .imm(imm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .illegal_op(illegal_op), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [XLEN-1:0] res;
    logic            z;
    logic            tk;
    logic [XLEN-1:0] tgt;
    logic            ill;
  } bundle_t;

  logic    m_valid;
  bundle_t m_b;
  int      m_cnt;

  function automatic bundle_t ref_bundle(input logic [3:0] op, input logic [1:0] bc,
      input logic br, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
      input logic [XLEN-1:0] p, input logic [XLEN-1:0] im);
    bundle_t r;
    logic c;
    r.ill = !(op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd6);
    case (op)
      4'd0: r.res = x & y;
      4'd1: r.res = x | y;
      4'd2: r.res = x + y;
      4'd6: r.res = x - y;
      default: r.res = '0;
    endcase
    r.z = (r.res == 0);
    if (bc == 2'd0)      c = (x == y);
    else if (bc == 2'd1) c = (x != y);
    else if (bc == 2'd2) c = ($signed(x) < $signed(y));
    else                 c = !($signed(x) < $signed(y));
    r.tk  = br && c && !r.ill;
    r.tgt = p + im * 2;
    return r;
  endfunction

  // One clock of traffic: drive, check against model, advance model across the edge.
  task automatic step(input logic iv, input logic [3:0] op, input logic [1:0] bc,
      input logic br, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
      input logic [XLEN-1:0] p, input logic [XLEN-1:0] im,
      input logic fl, input logic ordy);
    logic    exp_rdy;
    bundle_t nb;
    in_valid = iv; operation = op; Branchcontrol = bc; branch = br;
    a = x; b = y; pc = p; imm = im; flush = fl; out_ready = ordy;
    #1;
    exp_rdy = !fl && (!m_valid || ordy);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_valid);
    chk("taken_count", taken_count, m_cnt);
    if (m_valid) begin
      chk("result", result, m_b.res);
      chk("zero", zero, m_b.z);
      chk("branch_taken", branch_taken, m_b.tk);
      chk("branch_target", branch_target, m_b.tgt);
      chk("illegal_op", illegal_op, m_b.ill);
    end
    nb = ref_bundle(op, bc, br, x, y, p, im);
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0;
    end else begin
      if (m_valid && ordy && m_b.tk && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (iv && exp_rdy) begin
        m_valid = 1'b1;
        m_b     = nb;
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 4'd2, 2'd0, 1'b0, '0, '0, '0, '0, 1'b0, ordy);
  endtask

  logic [XLEN-1:0] hold_res;
  logic [3:0]      rop;
  logic [XLEN-1:0] ra, rb;

  initial begin
    reset = 1'b0;
    in_valid = 0; operation = 0; Branchcontrol = 0; branch = 0;
    a = 0; b = 0; pc = 0; imm = 0; flush = 0; out_ready = 0;
    m_valid = 0; m_cnt = 0;
    m_b = '{res: '0, z: 1'b0, tk: 1'b0, tgt: '0, ill: 1'b0};
    repeat (2) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst result", result, 0);
    chk("rst zero", zero, 0);
    chk("rst branch_taken", branch_taken, 0);
    chk("rst branch_target", branch_target, 0);
    chk("rst illegal_op", illegal_op, 0);
    chk("rst taken_count", taken_count, 0);
    reset = 1'b1;

    // ADD 5+7, accepted on the first edge after release
    step(1, 4'd2, 2'd0, 0, 64'd5, 64'd7, 64'h0, 64'h0, 0, 0);
    #1;
    chk("add out_valid", out_valid, 1);
    chk("add result", result, 64'd12);
    chk("add zero", zero, 0);
    chk("add illegal", illegal_op, 0);

    // SUB/BLT taken; drains the ADD in the same cycle
    step(1, 4'd6, 2'd2, 1, '1, 64'd1, 64'h1000, 64'd8, 0, 1);
    #1;
    chk("blt taken", branch_taken, 1);
    chk("blt target", branch_target, 64'h1010);
    chk("blt result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    step(1, 4'd6, 2'd3, 1, '1, 64'd1, 64'h1000, 64'd8, 0, 1);
    #1;
    chk("blt count", taken_count, 1);
    chk("bge taken", branch_taken, 0);

    step(1, 4'd6, 2'd0, 1, 64'h55, 64'h55, 64'h2000, 64'h10, 0, 1);
    #1;
    chk("beq zero", zero, 1);
    chk("beq taken", branch_taken, 1);
    step(1, 4'd6, 2'd1, 1, 64'h55, 64'h55, 64'h2000, 64'h10, 0, 1);
    #1;
    chk("bne taken", branch_taken, 0);

    // Backpressure: hold valid input, downstream stalls three cycles
    step(1, 4'd0, 2'd0, 0, 64'hF0F0, 64'hFF00, 64'h0, 64'h0, 0, 1);
    hold_res = result;
    repeat (3) step(1, 4'd1, 2'd0, 0, 64'hF0F0, 64'hFF00, 64'h0, 64'h0, 0, 0);
    chk("bp stable result", result, hold_res);
    step(1, 4'd1, 2'd0, 0, 64'hF0F0, 64'hFF00, 64'h0, 64'h0, 0, 1);
    #1;
    chk("bp new result", result, 64'hFFF0);
    idle(1);

    // Flush a held taken branch while downstream is ready
    step(1, 4'd2, 2'd0, 1, 64'h9, 64'h9, 64'h40, 64'h2, 0, 1);
    hold_res = taken_count;
    step(1, 4'd2, 2'd1, 1, 64'h1, 64'h2, 64'h40, 64'h2, 1, 1);
    #1;
    chk("flush out_valid", out_valid, 0);
    chk("flush count", taken_count, hold_res);

    step(1, 4'hF, 2'd0, 1, 64'h3, 64'h3, 64'h0, 64'h0, 0, 1);
    #1;
    chk("illegal flag", illegal_op, 1);
    chk("illegal result", result, 0);
    chk("illegal taken", branch_taken, 0);

    // Saturation with a 4-bit counter
    repeat (20) step(1, 4'd2, 2'd0, 1, 64'h7, 64'h7, 64'h0, 64'h4, 0, 1);
    idle(1);
    idle(1);
    chk("sat count", taken_count, 4'hF);

    // Reset asserted between edges while FULL
    step(1, 4'd2, 2'd0, 1, 64'h7, 64'h7, 64'h0, 64'h4, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst count", taken_count, 0);
    chk("midrst result", result, 0);
    m_valid = 0; m_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    step(1, 4'd2, 2'd0, 0, 64'd1, 64'd2, 64'h0, 64'h0, 0, 0);
    #1;
    chk("post-rst accept", out_valid, 1);

    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 4))
        0: rop = 4'd0;
        1: rop = 4'd1;
        2: rop = 4'd2;
        3: rop = 4'd6;
        default: rop = 4'($urandom);
      endcase
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
      step($urandom_range(0, 3) != 0, rop, 2'($urandom), 1'($urandom), ra, rb,
           {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
